// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver state encoding and framing constants.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } spi_rx_state_t;

    localparam int SPI_MIN_OVERSAMPLE = 4;
    localparam int SPI_DATA_W         = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, plus rise/fall detect
// from one extra history flop behind the synchronised value.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{rst_val}};
            prev_q <= rst_val;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver with valid/ready output and overrun flag.
// Define SPI_SLAVE_RX_FRAME_ERR_EN to add the frame_err truncation pulse.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    input  logic              rdy,
    output logic              dv,
    output logic [DATA_W-1:0] d,
    output logic              busy,
    output logic              overrun
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic sclk_s;
    logic sclk_rise;
    logic sclk_fall_unused;
    logic mosi_s;
    logic mosi_rise_unused;
    logic mosi_fall_unused;
    logic ss_s;
    logic ss_rise_unused;
    logic ss_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .rst_val  (1'b0),
        .async_in (sclk),
        .sync_out (sclk_s),
        .rise     (sclk_rise),
        .fall     (sclk_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk      (clk),
        .rst_n    (rst_n),
        .rst_val  (1'b0),
        .async_in (mosi),
        .sync_out (mosi_s),
        .rise     (mosi_rise_unused),
        .fall     (mosi_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk      (clk),
        .rst_n    (rst_n),
        .rst_val  (1'b1),
        .async_in (ss),
        .sync_out (ss_s),
        .rise     (ss_rise_unused),
        .fall     (ss_fall_unused)
    );

    spi_rx_state_t     state_q,   state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic [DATA_W-1:0] shift_in;
    logic [DATA_W-1:0] d_q,       d_d;
    logic              dv_q,      dv_d;
    logic              busy_q,    busy_d;
    logic              overrun_q, overrun_d;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    logic              frame_err_q, frame_err_d;
`endif

    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_in = {shift_q[DATA_W-2:0], mosi_s};
        end else begin
            shift_in = {mosi_s, shift_q[DATA_W-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        d_d       = d_q;
        dv_d      = dv_q;
        overrun_d = 1'b0;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (!ss_s) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Deselect wins over a coincident final rise: the word is discarded.
                if (ss_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    shift_d   = '0;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
                    frame_err_d = (bit_cnt_q != '0);
`endif
                end else if (sclk_rise) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d   = LOAD;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD: begin
                state_d = ss_s ? IDLE : SHIFT;
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // A pending unaccepted word has priority; the new one is dropped.
        if (state_q == LOAD) begin
            if (!dv_q || rdy) begin
                d_d  = shift_q;
                dv_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dv_q && rdy) begin
            dv_d = 1'b0;
        end

        busy_d = (state_d != IDLE) && (bit_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            d_q       <= '0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            d_q       <= d_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign dv      = dv_q;
    assign d       = d_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed self-checking bench for spi_slave_rx (MSB-first and LSB-first
// instances share the SPI lines; sclk runs at clk/8).
module tb_spi_slave_rx;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       sclk    = 1'b0;
    logic       mosi    = 1'b0;
    logic       ss      = 1'b1;
    logic       rdy     = 1'b1;
    logic       rdy_lsb = 1'b1;

    logic       dv;
    logic [7:0] d;
    logic       busy;
    logic       overrun;
    logic       dv_lsb;
    logic [7:0] d_lsb;
    logic       busy_lsb;
    logic       overrun_lsb;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    logic       frame_err;
    logic       frame_err_lsb;
`endif

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss        (ss),
        .rdy       (rdy),
        .dv        (dv),
        .d         (d),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(0)) u_dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss        (ss),
        .rdy       (rdy_lsb),
        .dv        (dv_lsb),
        .d         (d_lsb),
        .busy      (busy_lsb),
        .overrun   (overrun_lsb)
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err_lsb)
`endif
    );

    always #5 clk = ~clk;

    int         total_checks = 0;
    int         bad_checks   = 0;
    int         cycle        = 0;
    int         accepts      = 0;
    int         overruns     = 0;
    int         frame_errs   = 0;
    int         lsb_accepts  = 0;
    int         last_rise_cycle = 0;
    int         dv_rise_cycle   = 0;
    logic       prev_dv = 1'b0;
    logic [7:0] words [0:63];
    logic [7:0] lsb_last = 8'h00;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor on the falling edge: log accepted words, dv rise time and pulses
    always @(negedge clk) begin
        if (dv && rdy) begin
            words[accepts % 64] = d;
            accepts = accepts + 1;
        end
        if (dv && !prev_dv) dv_rise_cycle = cycle;
        prev_dv = dv;
        if (overrun) overruns = overruns + 1;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        if (frame_err) frame_errs = frame_errs + 1;
`endif
        if (dv_lsb && rdy_lsb) begin
            lsb_last = d_lsb;
            lsb_accepts = lsb_accepts + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks = total_checks + 1;
        if (got !== exp) begin
            bad_checks = bad_checks + 1;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Send nbits of value, 4 clk low then 4 clk high per bit; mosi changes with sclk fall
    task automatic applyStimulus(input logic [7:0] value, input int nbits, input bit msb_first);
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = msb_first ? value[7-i] : value[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            last_rise_cycle = cycle;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic setRdy(input logic v);
        @(posedge clk);
        #1 rdy = v;
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base_acc;
    int base_ovr;
    int base_ferr;
    int base_lsb;

    initial begin
        $display("[TB] start");

        waitClk(3);
        checkOutput("reset_dv", 32'(dv), 32'h0);
        checkOutput("reset_d", 32'(d), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        waitClk(4);

        // Single frame 8'h3B with rdy high
        base_acc = accepts; base_ovr = overruns;
        ss = 1'b0;
        waitClk(4);
        applyStimulus(8'h3B, 8, 1'b1);
        waitClk(10);
        checkOutput("single_count", 32'(accepts - base_acc), 32'd1);
        checkOutput("single_word", 32'(words[(accepts - 1) % 64]), 32'h3B);
        checkOutput("single_latency", 32'(dv_rise_cycle - last_rise_cycle), 32'd4);
        checkOutput("single_overrun", 32'(overruns - base_ovr), 32'd0);
        checkOutput("single_idle_busy", 32'(busy), 32'h0);
        ss = 1'b1;
        waitClk(6);

        // Back-to-back frames with ss held low
        base_acc = accepts;
        ss = 1'b0;
        waitClk(4);
        applyStimulus(8'h3B, 8, 1'b1);
        checkOutput("b2b_busy_between", 32'(busy), 32'h0);
        applyStimulus(8'h55, 8, 1'b1);
        waitClk(10);
        ss = 1'b1;
        waitClk(6);
        checkOutput("b2b_count", 32'(accepts - base_acc), 32'd2);
        checkOutput("b2b_first", 32'(words[base_acc % 64]), 32'h3B);
        checkOutput("b2b_second", 32'(words[(base_acc + 1) % 64]), 32'h55);

        // Stall: consumer not ready over two frames
        base_acc = accepts; base_ovr = overruns;
        setRdy(1'b0);
        ss = 1'b0;
        waitClk(4);
        applyStimulus(8'h3B, 8, 1'b1);
        applyStimulus(8'h55, 8, 1'b1);
        waitClk(10);
        checkOutput("stall_dv", 32'(dv), 32'h1);
        checkOutput("stall_d", 32'(d), 32'h3B);
        checkOutput("stall_overrun", 32'(overruns - base_ovr), 32'd1);
        checkOutput("stall_no_accept", 32'(accepts - base_acc), 32'd0);
        setRdy(1'b1);
        waitClk(3);
        checkOutput("stall_accept_count", 32'(accepts - base_acc), 32'd1);
        checkOutput("stall_accept_word", 32'(words[(accepts - 1) % 64]), 32'h3B);
        checkOutput("stall_dv_cleared", 32'(dv), 32'h0);
        ss = 1'b1;
        waitClk(6);

        // Truncated frame of 5 bits, then a full 8'h55
        base_acc = accepts; base_ovr = overruns; base_ferr = frame_errs;
        ss = 1'b0;
        waitClk(4);
        applyStimulus(8'hA8, 5, 1'b1);
        checkOutput("trunc_busy_mid", 32'(busy), 32'h1);
        ss = 1'b1;
        waitClk(6);
        checkOutput("trunc_busy_after", 32'(busy), 32'h0);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        checkOutput("trunc_frame_err", 32'(frame_errs - base_ferr), 32'd1);
`endif
        ss = 1'b0;
        waitClk(4);
        applyStimulus(8'h55, 8, 1'b1);
        waitClk(10);
        ss = 1'b1;
        waitClk(6);
        checkOutput("trunc_count", 32'(accepts - base_acc), 32'd1);
        checkOutput("trunc_word", 32'(words[(accepts - 1) % 64]), 32'h55);
        checkOutput("trunc_overrun", 32'(overruns - base_ovr), 32'd0);

        // Reset in the middle of 8'hA5, then receive 8'hC3
        base_acc = accepts;
        ss = 1'b0;
        waitClk(4);
        applyStimulus(8'hA5, 4, 1'b1);
        rst_n = 1'b0;
        waitClk(2);
        checkOutput("midrst_dv", 32'(dv), 32'h0);
        checkOutput("midrst_d", 32'(d), 32'h0);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        waitClk(6);
        applyStimulus(8'hC3, 8, 1'b1);
        waitClk(10);
        ss = 1'b1;
        waitClk(6);
        checkOutput("midrst_count", 32'(accepts - base_acc), 32'd1);
        checkOutput("midrst_word", 32'(words[(accepts - 1) % 64]), 32'hC3);

        // LSB-first 8'h3B: LSB instance rebuilds 3B, MSB instance sees DC
        base_lsb = lsb_accepts;
        ss = 1'b0;
        waitClk(4);
        applyStimulus(8'h3B, 8, 1'b0);
        waitClk(10);
        ss = 1'b1;
        waitClk(6);
        checkOutput("lsb_count", 32'(lsb_accepts - base_lsb), 32'd1);
        checkOutput("lsb_word", 32'(lsb_last), 32'h3B);
        checkOutput("lsb_seen_msb_inst", 32'(words[(accepts - 1) % 64]), 32'hDC);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI mode-0 slave receiver; the far end of the team's SPI master transmitter (mosi/ss/sclk).
- Samples oversampled sclk/mosi/ss in the local clk domain and deserialises DATA_W-bit frames.
- Presents each completed word on a valid/ready output port (dv/d) to downstream FPGA logic.
- Flags words lost while the consumer stalls.

Parameters:
- DATA_W, 8, bits per frame
- SYNC_STAGES, 2, synchroniser flops on sclk, mosi and ss (minimum 2)
- MSB_FIRST, 1, 1 = first received bit lands in d[DATA_W-1]; 0 = first bit lands in d[0]

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- sclk  in  1  SPI serial clock, asynchronous to clk; idle low
- mosi  in  1  serial data from master, asynchronous to clk
- ss  in  1  slave select, active low, asynchronous to clk
- rdy  in  1  downstream accepts d when dv && rdy
- dv  out  1  received word valid
- d  out  DATA_W  received word
- busy  out  1  frame in progress (ss asserted and bit count != 0)
- overrun  out  1  one-clk pulse: completed word dropped because dv was still pending

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, bit_cnt=0, shift reg=0, dv=0, d=0, busy=0, overrun=0. All synchroniser flops clear; ss synchroniser resets to 1. Reset mid-frame discards the partial word.
- Timing requirement: sclk period >= 4 clk periods; each sclk high/low phase >= 2 clk periods.
- Synchronise sclk, mosi and ss through SYNC_STAGES flops. Keep one extra sclk flop for edge detect: rise = sync & ~prev.
- Sampling: mosi is sampled on the synchronised sclk rise. mosi passes through the same stage count as sclk, so the sample stays aligned.
- FSM:
  - IDLE: ss_s high. Go to SHIFT when ss_s is low.
  - SHIFT: on each rise, shift in mosi and increment bit_cnt. On the rise that makes bit_cnt == DATA_W, go to LOAD and reset bit_cnt to 0.
  - SHIFT, ss_s high: go to IDLE, discard partial, bit_cnt=0. No dv, no overrun.
  - LOAD (one clk): transfer shift reg to output. Return to SHIFT if ss_s is low, else IDLE. Back-to-back frames with ss held low are supported.
- Output handshake:
  - dv rises one clk after LOAD, with d valid.
  - dv and d hold stable until a clk where dv && rdy; dv clears the next clk unless a new LOAD coincides.
  - LOAD while dv && !rdy: keep old d, drop the new word, overrun=1 for one clk.
  - LOAD in the same clk as dv && rdy: load the new word, dv stays 1, no overrun.
- Latency: dv asserts SYNC_STAGES+2 clk after the raw sclk rising edge of the last bit, with edge arrival up to 1 clk late from metastability.
- busy = (state != IDLE) && (bit_cnt != 0).
- Rises while ss_s is high are ignored.
- bit_cnt width is $clog2(DATA_W+1); it never exceeds DATA_W.

Optional Feature:
- Macro: SPI_SLAVE_RX_FRAME_ERR_EN
- Defined:
  - Adds output port frame_err, 1 bit, reset 0.
  - frame_err pulses for one clk when ss_s deasserts in SHIFT with 0 < bit_cnt < DATA_W.
  - It also pulses when ss_s deasserts within the same clk as the final rise is pending.
  - Partial data is still discarded.
- Undefined: no frame_err port; truncated frames are dropped silently.

Decomposition:
- Package spi_pkg:
  - state enum spi_rx_state_t {IDLE, SHIFT, LOAD}
  - SPI_MIN_OVERSAMPLE = 4 constant
  - default DATA_W constant, shared with the master transmitter
- Sub-module spi_sync_edge: parameterised SYNC_STAGES synchroniser with reset value input and rise/fall detect outputs. Instantiate it three times (sclk, mosi, ss).

Test Plan:
- Single frame: ss low, MSB-first 8'h3B, sclk = clk/8, rdy=1 -> one dv pulse with d=8'h3B, SYNC_STAGES+2 clk after last rise; overrun=0.
- Back-to-back: ss held low across 8'h3B then 8'h55 -> two dv pulses, d=8'h3B then 8'h55; busy low between frames.
- Stall: rdy=0 across both frames -> d stays 8'h3B with dv high; overrun pulses once at the second LOAD. Raising rdy gives exactly one accept, then dv=0.
- Truncation: ss rises after 5 bits, then a full 8'h55 -> only d=8'h55 is delivered; with SPI_SLAVE_RX_FRAME_ERR_EN, one frame_err pulse after the 5th bit.
- Reset mid-frame: rst_n low after 4 bits of 8'hA5, then release and send 8'hC3 -> outputs zero during reset; the next dv gives d=8'hC3.
- LSB-first: MSB_FIRST=0, 8'h3B sent LSB-first -> d=8'h3B.
